// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the FSM state encoding, default widths and the opcode/register field values.
package fetch_sequencer_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int INS_W_DEF  = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] OPCODE_NOP   = 4'h0;
  localparam logic [3:0] OPCODE_LOAD  = 4'h1;
  localparam logic [3:0] OPCODE_STORE = 4'h2;
  localparam logic [3:0] OPCODE_ADD   = 4'h3;
  localparam logic [3:0] OPCODE_SUB   = 4'h4;
  localparam logic [3:0] OPCODE_AND   = 4'h5;
  localparam logic [3:0] OPCODE_OR    = 4'h6;
  localparam logic [3:0] OPCODE_XOR   = 4'h7;

  localparam logic [1:0] R0 = 2'd0;
  localparam logic [1:0] R1 = 2'd1;
  localparam logic [1:0] R2 = 2'd2;
  localparam logic [1:0] R3 = 2'd3;

endpackage

// File: rtl/fetch_sequencer.sv
// Program sequencer: walks an external program memory from address 0 to END_ADDR,
// issuing one registered instruction per FETCH/ISSUE pair, with stall, step and abort.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int INS_W    = INS_W_DEF,
  parameter int END_ADDR = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  input  logic              halt_req,
  input  logic              stall,
  input  logic [INS_W-1:0]  ins_in,
  output logic [ADDR_W-1:0] addr,
  output logic [INS_W-1:0]  ins_out,
  output logic              ins_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(END_ADDR);

  state_t             r_state;
  state_t             w_state_next;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_next;
  logic [INS_W-1:0]   r_ins;
  logic [INS_W-1:0]   w_ins_next;
  logic               r_done;
  logic               w_done_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ins   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_ins   <= w_ins_next;
      r_done  <= w_done_next;
    end
  end

  // Abort outranks everything; the held instruction is simply never marked valid again.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ins_next   = r_ins;
    w_done_next  = r_done;
    if (halt_req) begin
      w_state_next = S_HALT;
      w_done_next  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            w_state_next = S_FETCH;
            w_pc_next    = '0;
            w_done_next  = 1'b0;
          end
        end
        S_FETCH: begin
          w_ins_next   = ins_in;
          w_state_next = S_ISSUE;
        end
        S_ISSUE: begin
          if (!stall) begin
            if (r_pc == LAST_PC) begin
              w_state_next = S_HALT;
              w_done_next  = 1'b1;
            end else begin
              w_pc_next    = r_pc + 1'b1;
              w_state_next = step_mode ? S_WAIT : S_FETCH;
            end
          end
        end
        S_WAIT: begin
          if (step) begin
            w_state_next = S_FETCH;
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  assign addr      = r_pc;
  assign ins_out   = r_ins;
  assign ins_valid = (r_state == S_ISSUE);
  assign busy      = (r_state == S_FETCH) || (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign done      = r_done;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: a per-cycle vector table plus hand-written multi-cycle sequences.
// Instance A ends at address 16, instance B at 31 (full address range).
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, step_mode, step, halt_req, stall;
  logic [5:0] ins_in_a, ins_in_b;
  logic [4:0] addr_a, addr_b;
  logic [5:0] ins_out_a, ins_out_b;
  logic       valid_a, valid_b, busy_a, busy_b, done_a, done_b;

  logic [5:0] mem [0:31];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ins_in_a = mem[addr_a];
  assign ins_in_b = mem[addr_b];

  fetch_sequencer #(.ADDR_W(5), .INS_W(6), .END_ADDR(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step(step),
    .halt_req(halt_req), .stall(stall), .ins_in(ins_in_a), .addr(addr_a),
    .ins_out(ins_out_a), .ins_valid(valid_a), .busy(busy_a), .done(done_a)
  );

  fetch_sequencer #(.ADDR_W(5), .INS_W(6), .END_ADDR(31)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step(step),
    .halt_req(halt_req), .stall(stall), .ins_in(ins_in_b), .addr(addr_b),
    .ins_out(ins_out_b), .ins_valid(valid_b), .busy(busy_b), .done(done_b)
  );

  typedef struct {
    logic       start;
    logic       step_mode;
    logic       step;
    logic       halt_req;
    logic       stall;
    logic [4:0] e_addr;
    logic [5:0] e_ins;
    logic       e_valid;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t vecs [0:12];

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end else begin
      $display("ok   %s: %0d", name, actual);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; step_mode = 0; step = 0; halt_req = 0; stall = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " addr"}, addr_a, 0);
    chk({tag, " ins_out"}, ins_out_a, 0);
    chk({tag, " ins_valid"}, valid_a, 0);
    chk({tag, " busy"}, busy_a, 0);
    chk({tag, " done"}, done_a, 0);
  endtask

  initial begin
    int k_a, k_b, last_cyc, n_valid;
    logic seen;
    logic [4:0] issued [$];

    for (int i = 0; i < 32; i++) mem[i] = 6'((i * 7 + 1) % 64);

    // {start, step_mode, step, halt_req, stall} -> {addr, ins_out, valid, busy, done} after the edge
    vecs[0]  = '{1, 0, 0, 0, 0, 5'd0, 6'd0,  0, 1, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 5'd0, 6'd1,  1, 1, 0};
    vecs[2]  = '{0, 0, 0, 0, 1, 5'd0, 6'd1,  1, 1, 0};
    vecs[3]  = '{1, 0, 0, 0, 0, 5'd1, 6'd1,  0, 1, 0};
    vecs[4]  = '{0, 0, 0, 0, 0, 5'd1, 6'd8,  1, 1, 0};
    vecs[5]  = '{0, 1, 0, 0, 0, 5'd2, 6'd8,  0, 1, 0};
    vecs[6]  = '{1, 1, 0, 0, 0, 5'd2, 6'd8,  0, 1, 0};
    vecs[7]  = '{1, 1, 1, 0, 0, 5'd2, 6'd8,  0, 1, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 5'd2, 6'd15, 1, 1, 0};
    vecs[9]  = '{0, 0, 0, 1, 0, 5'd2, 6'd15, 0, 0, 0};
    vecs[10] = '{1, 0, 0, 1, 0, 5'd2, 6'd15, 0, 0, 0};
    vecs[11] = '{1, 0, 0, 0, 0, 5'd0, 6'd15, 0, 1, 0};
    vecs[12] = '{0, 0, 0, 1, 0, 5'd0, 6'd15, 0, 0, 0};

    // Reset state
    do_reset();
    check_all_zero("reset");

    // Table-driven cycle vectors
    for (int v = 0; v < 13; v++) begin
      start = vecs[v].start; step_mode = vecs[v].step_mode; step = vecs[v].step;
      halt_req = vecs[v].halt_req; stall = vecs[v].stall;
      tick();
      chk($sformatf("vec%0d addr", v), addr_a, vecs[v].e_addr);
      chk($sformatf("vec%0d ins_out", v), ins_out_a, vecs[v].e_ins);
      chk($sformatf("vec%0d valid", v), valid_a, vecs[v].e_valid);
      chk($sformatf("vec%0d busy", v), busy_a, vecs[v].e_busy);
      chk($sformatf("vec%0d done", v), done_a, vecs[v].e_done);
    end
    clear_inputs();

    // Free run on both instances: A stops at 16, B covers the full range to 31
    do_reset();
    pulse_start();
    k_a = 0; k_b = 0; last_cyc = 0;
    for (int c = 1; c <= 120 && !(done_a && done_b); c++) begin
      tick();
      if (valid_a) begin
        chk($sformatf("run A issue%0d addr", k_a), addr_a, k_a);
        chk($sformatf("run A issue%0d ins", k_a), ins_out_a, mem[k_a]);
        if (k_a > 0) chk($sformatf("run A issue%0d spacing", k_a), c - last_cyc, 2);
        last_cyc = c;
        k_a++;
      end
      if (valid_b) begin
        if (addr_b != 5'(k_b) || ins_out_b != mem[k_b])
          chk($sformatf("run B issue%0d addr", k_b), addr_b, k_b);
        k_b++;
      end
    end
    chk("run A issue count", k_a, 17);
    chk("run A done", done_a, 1);
    chk("run A final pc", addr_a, 16);
    chk("run B issue count", k_b, 32);
    chk("run B done", done_b, 1);
    chk("run B final pc", addr_b, 31);
    repeat (4) tick();
    chk("run B pc no wrap", addr_b, 31);
    chk("run B no valid after halt", valid_b, 0);

    // Stall for 3 cycles during the issue of address 5
    do_reset();
    pulse_start();
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (valid_a && addr_a == 5) seen = 1;
      else tick();
    end
    chk("stall reached addr5", seen, 1);
    n_valid = valid_a;
    for (int s = 0; s < 3; s++) begin
      stall = 1;
      tick();
      n_valid += valid_a;
      chk($sformatf("stall cyc%0d ins held", s), ins_out_a, mem[5]);
    end
    stall = 0;
    tick();
    chk("stall valid cycles", n_valid, 4);
    chk("stall next fetch addr", addr_a, 6);
    chk("stall next is fetch", valid_a, 0);

    // Step mode: three step pulses 5 cycles apart -> addresses 0..3 issued
    do_reset();
    step_mode = 1;
    pulse_start();
    issued.delete();
    for (int c = 1; c <= 30; c++) begin
      step = (c == 6 || c == 11 || c == 16);
      tick();
      if (valid_a) issued.push_back(addr_a);
    end
    step = 0;
    chk("step issue count", issued.size(), 4);
    for (int i = 0; i < issued.size() && i < 4; i++)
      chk($sformatf("step issue%0d addr", i), issued[i], i);
    chk("step waits at addr4", addr_a, 4);
    chk("step still busy", busy_a, 1);
    step_mode = 0;

    // Abort at the issue of address 7, then restart from 0
    do_reset();
    pulse_start();
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (valid_a && addr_a == 7) seen = 1;
      else tick();
    end
    chk("abort reached addr7", seen, 1);
    halt_req = 1;
    tick();
    halt_req = 0;
    chk("abort busy", busy_a, 0);
    chk("abort done", done_a, 0);
    chk("abort pc held", addr_a, 7);
    n_valid = 0;
    repeat (6) begin tick(); n_valid += valid_a; end
    chk("abort no valid", n_valid, 0);
    pulse_start();
    tick();
    chk("restart valid", valid_a, 1);
    chk("restart addr", addr_a, 0);
    chk("restart ins", ins_out_a, mem[0]);

    // Reset during a stall at address 9, then start while busy is ignored
    do_reset();
    pulse_start();
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (valid_a && addr_a == 9) seen = 1;
      else tick();
    end
    chk("midrst reached addr9", seen, 1);
    stall = 1;
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    stall = 0;
    check_all_zero("midrst");
    pulse_start();
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (valid_a && addr_a == 3) seen = 1;
      else tick();
    end
    chk("busy-start reached addr3", seen, 1);
    pulse_start();
    chk("busy-start ignored addr", addr_a, 4);
    tick();
    chk("busy-start ignored ins", ins_out_a, mem[4]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameters SHALL be ADDR_W, default 5, program-memory address width; INS_W, default 6, instruction width ({opcode[3:0], reg[1:0]}); END_ADDR, default 31, last address executed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 start  in  1  pulse; begins a program run from address 0 when idle or halted.
REQ-005 step_mode  in  1  1 = issue one instruction per step pulse; sampled at each issue.
REQ-006 step  in  1  pulse; releases the next fetch while in WAIT.
REQ-007 halt_req  in  1  abort request; highest priority after reset.
REQ-008 stall  in  1  datapath not ready; holds the issued instruction.
REQ-009 ins_in  in  INS_W  combinational instruction read data from program memory.
REQ-010 addr  out  ADDR_W  program-memory address (registered PC).
REQ-011 ins_out  out  INS_W  registered instruction to the datapath.
REQ-012 ins_valid  out  1  ins_out valid this cycle.
REQ-013 busy  out  1  high in FETCH, ISSUE or WAIT.
REQ-014 done  out  1  high in HALT after END_ADDR has issued; low after an abort.

Function
REQ-015 The FSM SHALL have the states IDLE, FETCH, ISSUE, WAIT and HALT.
REQ-016 From IDLE or HALT, start SHALL load PC=0 and go to FETCH; start SHALL be ignored while busy.
REQ-017 In FETCH, addr SHALL equal PC, ins_in SHALL be captured into ins_out at the clock edge, and the next state SHALL be ISSUE.
REQ-018 In ISSUE, ins_valid SHALL be 1; while stall=1 the FSM SHALL stay in ISSUE with ins_out and PC held.
REQ-019 In ISSUE with stall=0, if PC==END_ADDR the next state SHALL be HALT with done=1 and PC held; otherwise PC SHALL increment by 1.
REQ-020 When REQ-019 increments PC, the next state SHALL be WAIT if step_mode=1, else FETCH.
REQ-021 In WAIT, ins_valid SHALL be 0; step=1 SHALL move the FSM to FETCH; other inputs SHALL hold it in WAIT.
REQ-022 Latency SHALL be start at cycle N -> FETCH at N+1 -> ins_valid with Mem[0] at N+2; free-run throughput SHALL be one instruction per 2 cycles with no stall.
REQ-023 PC arithmetic SHALL be ADDR_W-bit unsigned; with END_ADDR=2^ADDR_W-1, PC SHALL never wrap because HALT is entered first.
REQ-024 halt_req=1 in any busy state SHALL force HALT on the next edge with done=0, ins_valid=0 and PC held; an instruction held by stall SHALL be dropped.
REQ-025 If halt_req and start are both high in IDLE or HALT, halt_req SHALL win and the state SHALL remain or become HALT.
REQ-026 If step and start arrive together in WAIT, start SHALL be ignored and step SHALL be honoured.
REQ-027 Opcode contents SHALL NOT affect sequencing; OPCODE_NOP SHALL be issued like any other instruction.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE with PC=0, addr=0, ins_out=0, ins_valid=0, busy=0 and done=0.
REQ-029 Reset SHALL override every other input, including mid-run and mid-stall.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, INS_W/ADDR_W defaults and the opcode/register constants (OPCODE_*, R0..R3).
REQ-031 The block SHALL be a single module with no sub-modules; program memory SHALL stay external and connect via addr/ins_in.

Verification
REQ-032 Free-run: reset, start pulse, END_ADDR=16 -> 17 ins_valid pulses every 2nd cycle, ins_out matching Mem[0..16] in order, done=1 after address 16, PC=16.
REQ-033 Stall: stall=1 for 3 cycles during issue of address 5 -> ins_valid high for 4 cycles, ins_out constant, then address 6 fetched.
REQ-034 Step mode: step_mode=1, start, three step pulses 5 cycles apart -> exactly 4 issues (addresses 0-3), ins_valid=0 between steps.
REQ-035 Abort: halt_req at issue of address 7 -> HALT next edge, done=0, no further ins_valid; then start -> restart at address 0.
REQ-036 Reset mid-run: rst_n=0 during a stall at address 9 -> IDLE, all outputs 0 next cycle; start while busy produces no restart.
REQ-037 Boundary: END_ADDR=31 -> 32 issues, PC stops at 31 without wrapping to 0, done=1.
